aer_event_fifo: RTL and testbench
=================================

// Module: aer_event_fifo
// PURPOSE
//  Clocked, parametrised successor to the one-bit AER delay buffer. Sits between an AER sender
//  and receiver in the FinalAERProtocol chain. Accepts address events on a 4-phase req/ack
//  bundled-data link and queues them in a DEPTH-entry FIFO. Re-issues them in order on a second
//  4-phase link. Decouples sender and receiver rates; optional drop mode when full.
// PARAMETERS
//  ADDR_W         8   width of an AER event address
//  DEPTH          16  FIFO entries; power of two, >=2
//  SYNC_STAGES    2   flops in each req/ack synchroniser, >=2
//  DROP_WHEN_FULL 0   0: withhold in_ack while full (backpressure); 1: ack and discard event
// PORTS
//  clk        in   1                   system clock, all state on rising edge
//  rst_n      in   1                   asynchronous, active-low reset
//  in_req     in   1                   sender request (asynchronous to clk)
//  in_addr    in   ADDR_W              event address, stable while in_req=1 until in_ack=1
//  in_ack     out  1                   acknowledge to sender
//  out_req    out  1                   request to receiver
//  out_addr   out  ADDR_W              queued address, registered
//  out_ack    in   1                   receiver acknowledge (asynchronous to clk)
//  count      out  $clog2(DEPTH)+1     entries held, 0..DEPTH
//  full       out  1                   count==DEPTH
//  empty      out  1                   count==0
//  dropped    out  16                  events discarded in drop mode, saturates at 16'hFFFF
// BEHAVIOUR
//  - Reset (async assert, sync-released by flops): in_ack=0, out_req=0, out_addr=0, count=0,
//    full=0, empty=1, dropped=0, pointers=0, synchronisers=0. RX FSM enters RX_WAITLOW. TX FSM
//    enters TX_IDLE.
//  - req_s/ack_s: in_req/out_ack after SYNC_STAGES flops. Only the synchronised copies drive FSMs.
//  - RX FSM:
//      RX_IDLE    -> req_s=1 & !full: write in_addr at wptr, wptr++, in_ack<=1, go RX_WAITLOW.
//      RX_IDLE    -> req_s=1 & full & DROP_WHEN_FULL=1: no write, dropped++ (sat.), in_ack<=1, go RX_WAITLOW.
//      RX_IDLE    -> req_s=1 & full & DROP_WHEN_FULL=0: stay RX_IDLE, in_ack=0 (event held by sender).
//      RX_WAITLOW -> req_s=0: in_ack<=0, go RX_IDLE.
//      Resetting into RX_WAITLOW prevents a request spanning reset from being accepted twice.
//  - TX FSM:
//      TX_IDLE -> !empty & ack_s=0: out_addr<=mem[rptr], out_req<=1, go TX_REQ.
//      TX_REQ  -> ack_s=1: rptr++, out_req<=0, go TX_REL.
//      TX_REL  -> ack_s=0: go TX_IDLE.
//      out_addr holds its value from the out_req rise until the next load.
//  - Pointers: $clog2(DEPTH)+1 bits, wrap modulo 2*DEPTH. count=wptr-rptr. full/empty are
//    decoded combinationally from count.
//  - A write and a pop in the same cycle leave count unchanged. A write while full is never
//    enabled by a same-cycle pop (no bypass).
//  - Latency, empty FIFO, in_req rise settled before edge 0:
//      req_s=1 after edge SYNC_STAGES-1.
//      Write and in_ack=1 at edge SYNC_STAGES.
//      out_req=1 at edge SYNC_STAGES+1.
//  - Events leave in arrival order. No event is lost or duplicated when DROP_WHEN_FULL=0.
//  - Reset mid-handshake: in_ack/out_req drop asynchronously and the queue is discarded. TX
//    issues nothing until out_ack_s=0.
// STRUCTURE
//  - aer_pkg holds:
//      RX_IDLE/RX_WAITLOW and TX_IDLE/TX_REQ/TX_REL state localparams;
//      the AER_ADDR_W default;
//      the clog2 helper function.
//  - One sub-module aer_sync (SYNC_STAGES-deep, async-reset-to-0 synchroniser), instantiated
//    for in_req and out_ack.
//  - FIFO storage (reg array), pointers and both FSMs are inline in aer_event_fifo.
// TESTING
//  1. Single event: in_addr=8'hA5, full 4-phase exchange -> in_ack high at edge 2 (SYNC_STAGES=2),
//     out_req high at edge 3, out_addr=8'hA5, count 1->0 after out_ack.
//  2. Burst of 16 events, out_ack held 0 -> count=16, full=1. 17th in_req gets no in_ack. After one
//     out handshake the 17th is accepted. Output order is 0..16 exactly.
//  3. DROP_WHEN_FULL=1, FIFO full, 3 extra events -> each acked, dropped=3, count stays 16, no
//     corruption of queued data.
//  4. Wrap-around: 40 events with a random-rate receiver -> addresses out in order, count never >16,
//     pointers cross the wrap boundary twice.
//  5. Simultaneous push/pop at count=5 -> count stays 5, both events correct.
//  6. rst_n low while in_req=1 and out_req=1 -> in_ack=0/out_req=0 immediately, empty=1. After
//     release, the held in_req is not accepted until it drops and rises again.

Source files
------------

// File: rtl/aer_pkg.sv
// Shared types and helpers for the AER event FIFO: FSM state encodings,
// default address width and a constant-foldable ceil(log2) helper.
package aer_pkg;

  localparam int unsigned AER_ADDR_W = 8;

  typedef enum logic {
    RX_IDLE,
    RX_WAITLOW
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_REQ,
    TX_REL
  } tx_state_t;

  // ceil(log2(v)); returns 0 for v <= 1
  function automatic int unsigned aer_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = 32'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/aer_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit level; resets to 0.
module aer_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/aer_event_fifo.sv
// Clocked AER event queue: 4-phase req/ack in, DEPTH-entry FIFO, 4-phase req/ack out,
// with optional discard-when-full mode and a saturating drop counter.
module aer_event_fifo
  import aer_pkg::*;
#(
  parameter int unsigned ADDR_W         = AER_ADDR_W,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned DROP_WHEN_FULL = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_req,
  input  logic [ADDR_W-1:0]          in_addr,
  output logic                       in_ack,
  output logic                       out_req,
  output logic [ADDR_W-1:0]          out_addr,
  input  logic                       out_ack,
  output logic [aer_clog2(DEPTH):0]  count,
  output logic                       full,
  output logic                       empty,
  output logic [15:0]                dropped
);

  localparam int unsigned PTR_W = aer_clog2(DEPTH) + 1;
  localparam int unsigned IDX_W = PTR_W - 1;
  localparam int unsigned SET_W = aer_clog2(SYNC_STAGES) + 1;

  logic              req_s;
  logic              ack_s;
  rx_state_t         rx_state, rx_next;
  tx_state_t         tx_state, tx_next;
  logic [PTR_W-1:0]  wptr, rptr, wptr_next, rptr_next;
  logic              in_ack_next, out_req_next;
  logic [ADDR_W-1:0] out_addr_next;
  logic [15:0]       dropped_next;
  logic              wr_en;
  logic [SET_W-1:0]  settle;
  logic              settled;
  logic [ADDR_W-1:0] mem [DEPTH];

  aer_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (in_req),
    .q     (req_s)
  );

  aer_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (out_ack),
    .q     (ack_s)
  );

  assign count   = wptr - rptr;
  assign full    = (count == PTR_W'(DEPTH));
  assign empty   = (count == '0);
  // Synchroniser outputs read 0 straight after reset regardless of the pins; wait
  // until they have been refilled before trusting a low level.
  assign settled = (settle == SET_W'(SYNC_STAGES));

  // Receive side next-state and acknowledge
  always_comb begin
    rx_next      = rx_state;
    in_ack_next  = in_ack;
    wptr_next    = wptr;
    dropped_next = dropped;
    wr_en        = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (req_s) begin
          if (!full) begin
            wr_en       = 1'b1;
            wptr_next   = wptr + PTR_W'(1);
            in_ack_next = 1'b1;
            rx_next     = RX_WAITLOW;
          end else if (DROP_WHEN_FULL != 0) begin
            if (dropped != 16'hFFFF) dropped_next = dropped + 16'd1;
            in_ack_next = 1'b1;
            rx_next     = RX_WAITLOW;
          end
        end
      end
      RX_WAITLOW: begin
        if (settled && !req_s) begin
          in_ack_next = 1'b0;
          rx_next     = RX_IDLE;
        end
      end
    endcase
  end

  // Transmit side next-state, request and address load
  always_comb begin
    tx_next       = tx_state;
    out_req_next  = out_req;
    out_addr_next = out_addr;
    rptr_next     = rptr;
    case (tx_state)
      TX_IDLE: begin
        if (settled && !empty && !ack_s) begin
          out_addr_next = mem[rptr[IDX_W-1:0]];
          out_req_next  = 1'b1;
          tx_next       = TX_REQ;
        end
      end
      TX_REQ: begin
        if (ack_s) begin
          rptr_next    = rptr + PTR_W'(1);
          out_req_next = 1'b0;
          tx_next      = TX_REL;
        end
      end
      TX_REL: begin
        if (!ack_s) tx_next = TX_IDLE;
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_WAITLOW;
      tx_state <= TX_IDLE;
      wptr     <= '0;
      rptr     <= '0;
      in_ack   <= 1'b0;
      out_req  <= 1'b0;
      out_addr <= '0;
      dropped  <= '0;
      settle   <= '0;
    end else begin
      rx_state <= rx_next;
      tx_state <= tx_next;
      wptr     <= wptr_next;
      rptr     <= rptr_next;
      in_ack   <= in_ack_next;
      out_req  <= out_req_next;
      out_addr <= out_addr_next;
      dropped  <= dropped_next;
      if (!settled) settle <= settle + SET_W'(1);
    end
  end

  // Storage has no reset; contents are only visible once written
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[IDX_W-1:0]] <= in_addr;
  end

endmodule

// File: tb/tb_aer_event_fifo.sv
// Self-checking bench for aer_event_fifo: a backpressure instance and a drop-mode
// instance, driven by 4-phase sender/receiver tasks and checked against an ordered queue.
module tb_aer_event_fifo;

  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = 5;
  localparam int          BOUND = 300;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n;
  logic [1:0]            in_req, in_ack, out_req, out_ack, full, empty;
  logic [1:0][AW-1:0]    in_addr, out_addr;
  logic [1:0][CW-1:0]    count;
  logic [1:0][15:0]      dropped;

  int vectors     = 0;
  int miscompares = 0;
  logic [AW-1:0] exp_q[$];

  aer_event_fifo #(.ADDR_W(AW), .DEPTH(DEPTH), .SYNC_STAGES(2), .DROP_WHEN_FULL(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_req(in_req[0]), .in_addr(in_addr[0]), .in_ack(in_ack[0]),
    .out_req(out_req[0]), .out_addr(out_addr[0]), .out_ack(out_ack[0]),
    .count(count[0]), .full(full[0]), .empty(empty[0]), .dropped(dropped[0])
  );

  aer_event_fifo #(.ADDR_W(AW), .DEPTH(DEPTH), .SYNC_STAGES(2), .DROP_WHEN_FULL(1)) dut_drop (
    .clk(clk), .rst_n(rst_n),
    .in_req(in_req[1]), .in_addr(in_addr[1]), .in_ack(in_ack[1]),
    .out_req(out_req[1]), .out_addr(out_addr[1]), .out_ack(out_ack[1]),
    .count(count[1]), .full(full[1]), .empty(empty[1]), .dropped(dropped[1])
  );

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Full 4-phase exchange as the sender; ok=0 if either ack edge never arrives
  task automatic send_event(input bit sel, input logic [AW-1:0] a, output bit ok);
    int n;
    ok = 1'b1;
    in_addr[sel] = a;
    in_req[sel]  = 1'b1;
    n = 0;
    while (in_ack[sel] !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
    if (in_ack[sel] !== 1'b1) ok = 1'b0;
    in_req[sel] = 1'b0;
    n = 0;
    while (in_ack[sel] !== 1'b0 && n < BOUND) begin @(negedge clk); n++; end
    if (in_ack[sel] !== 1'b0) ok = 1'b0;
  endtask

  // Full 4-phase exchange as the receiver
  task automatic recv_event(input bit sel, output logic [AW-1:0] a, output bit ok);
    int n;
    ok = 1'b1;
    a  = '0;
    n  = 0;
    while (out_req[sel] !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
    if (out_req[sel] !== 1'b1) ok = 1'b0;
    a = out_addr[sel];
    out_ack[sel] = 1'b1;
    n = 0;
    while (out_req[sel] !== 1'b0 && n < BOUND) begin @(negedge clk); n++; end
    if (out_req[sel] !== 1'b0) ok = 1'b0;
    out_ack[sel] = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_req = '0; out_ack = '0; in_addr = '0;
    idle(3);
    vectors++; if (in_ack !== 2'b00) begin miscompares++; $display("FAIL reset_in_ack got %b want 00", in_ack); end
    vectors++; if (out_req !== 2'b00) begin miscompares++; $display("FAIL reset_out_req got %b want 00", out_req); end
    vectors++; if (out_addr[0] !== 8'h00) begin miscompares++; $display("FAIL reset_out_addr got %h want 00", out_addr[0]); end
    vectors++; if (count[0] !== 5'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", count[0]); end
    vectors++; if (full !== 2'b00) begin miscompares++; $display("FAIL reset_full got %b want 00", full); end
    vectors++; if (empty !== 2'b11) begin miscompares++; $display("FAIL reset_empty got %b want 11", empty); end
    vectors++; if (dropped[1] !== 16'd0) begin miscompares++; $display("FAIL reset_dropped got %0d want 0", dropped[1]); end
    rst_n = 1'b1;
    idle(6);
  endtask

  task automatic test_single;
    logic [1:0] ack_at, req_at;
    bit ok;
    int n;
    in_addr[0] = 8'hA5;
    in_req[0]  = 1'b1;
    for (int e = 0; e < 4; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin
        vectors++; if (in_ack[0] !== 1'b0) begin miscompares++; $display("FAIL single_ack_edge1 got %b want 0", in_ack[0]); end
      end
      if (e == 2) begin
        ack_at = {out_req[0], in_ack[0]};
        vectors++; if (ack_at !== 2'b01) begin miscompares++; $display("FAIL single_edge2 {out_req,in_ack} got %b want 01", ack_at); end
        vectors++; if (count[0] !== 5'd1) begin miscompares++; $display("FAIL single_count_edge2 got %0d want 1", count[0]); end
      end
      if (e == 3) begin
        req_at = {out_req[0], in_ack[0]};
        vectors++; if (req_at !== 2'b11) begin miscompares++; $display("FAIL single_edge3 {out_req,in_ack} got %b want 11", req_at); end
        vectors++; if (out_addr[0] !== 8'hA5) begin miscompares++; $display("FAIL single_addr got %h want a5", out_addr[0]); end
      end
    end
    @(negedge clk);
    in_req[0]  = 1'b0;
    out_ack[0] = 1'b1;
    n = 0;
    while (out_req[0] !== 1'b0 && n < BOUND) begin @(negedge clk); n++; end
    ok = (out_req[0] === 1'b0);
    vectors++; if (!ok) begin miscompares++; $display("FAIL single_out_release got out_req=%b want 0", out_req[0]); end
    vectors++; if (count[0] !== 5'd0) begin miscompares++; $display("FAIL single_count_after got %0d want 0", count[0]); end
    out_ack[0] = 1'b0;
    idle(6);
  endtask

  task automatic test_burst;
    bit ok;
    int n;
    logic [AW-1:0] a;
    out_ack[0] = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(AW'(i));
      send_event(1'b0, AW'(i), ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL burst_send%0d got no handshake want handshake", i); end
    end
    idle(4);
    vectors++; if (count[0] !== 5'd16) begin miscompares++; $display("FAIL burst_count got %0d want 16", count[0]); end
    vectors++; if (full[0] !== 1'b1) begin miscompares++; $display("FAIL burst_full got %b want 1", full[0]); end
    in_addr[0] = 8'd16;
    in_req[0]  = 1'b1;
    exp_q.push_back(8'd16);
    idle(12);
    vectors++; if (in_ack[0] !== 1'b0) begin miscompares++; $display("FAIL burst_17th_blocked got in_ack=%b want 0", in_ack[0]); end
    recv_event(1'b0, a, ok);
    vectors++; if (!ok || a !== exp_q[0]) begin miscompares++; $display("FAIL burst_first_out got %h ok=%0d want %h", a, ok, exp_q[0]); end
    void'(exp_q.pop_front());
    n = 0;
    while (in_ack[0] !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
    vectors++; if (in_ack[0] !== 1'b1) begin miscompares++; $display("FAIL burst_17th_accept got in_ack=%b want 1", in_ack[0]); end
    in_req[0] = 1'b0;
    idle(4);
    for (int i = 1; i <= 16; i++) begin
      recv_event(1'b0, a, ok);
      vectors++; if (!ok || a !== exp_q[0]) begin miscompares++; $display("FAIL burst_order%0d got %h ok=%0d want %h", i, a, ok, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    idle(4);
    vectors++; if (empty[0] !== 1'b1) begin miscompares++; $display("FAIL burst_drained got empty=%b want 1", empty[0]); end
  endtask

  task automatic test_drop;
    bit ok;
    logic [AW-1:0] a;
    logic [AW-1:0] q[$];
    out_ack[1] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a = AW'($urandom);
      q.push_back(a);
      send_event(1'b1, a, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL drop_fill%0d got no handshake want handshake", i); end
    end
    for (int i = 0; i < 3; i++) begin
      send_event(1'b1, AW'($urandom), ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL drop_extra%0d got no ack want ack", i); end
    end
    idle(3);
    vectors++; if (dropped[1] !== 16'd3) begin miscompares++; $display("FAIL drop_count got %0d want 3", dropped[1]); end
    vectors++; if (count[1] !== 5'd16) begin miscompares++; $display("FAIL drop_fifo_count got %0d want 16", count[1]); end
    for (int i = 0; i < 16; i++) begin
      recv_event(1'b1, a, ok);
      vectors++; if (!ok || a !== q[0]) begin miscompares++; $display("FAIL drop_data%0d got %h ok=%0d want %h", i, a, ok, q[0]); end
      void'(q.pop_front());
    end
    idle(4);
    vectors++; if (empty[1] !== 1'b1) begin miscompares++; $display("FAIL drop_drained got empty=%b want 1", empty[1]); end
  endtask

  task automatic test_wrap;
    int got = 0;
    int maxc = 0;
    exp_q.delete();
    fork
      begin
        bit ok;
        logic [AW-1:0] a;
        for (int i = 0; i < 40; i++) begin
          idle($urandom_range(0, 3));
          a = AW'($urandom);
          exp_q.push_back(a);
          send_event(1'b0, a, ok);
          vectors++; if (!ok) begin miscompares++; $display("FAIL wrap_send%0d got no handshake want handshake", i); end
        end
      end
      begin
        bit ok;
        logic [AW-1:0] a;
        logic [AW-1:0] e;
        for (int i = 0; i < 40; i++) begin
          idle($urandom_range(0, 8));
          recv_event(1'b0, a, ok);
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          vectors++; if (!ok || a !== e) begin miscompares++; $display("FAIL wrap_order%0d got %h ok=%0d want %h", i, a, ok, e); end
          got++;
        end
      end
      begin
        int n = 0;
        while (got < 40 && n < 20000) begin
          @(negedge clk);
          if (int'(count[0]) > maxc) maxc = int'(count[0]);
          n++;
        end
      end
    join
    vectors++; if (maxc > 16) begin miscompares++; $display("FAIL wrap_max_count got %0d want <=16", maxc); end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL wrap_leftover got %0d want 0", exp_q.size()); end
    idle(4);
  endtask

  task automatic test_simul;
    bit ok;
    bit stable = 1'b1;
    int n;
    logic [AW-1:0] a;
    exp_q.delete();
    out_ack[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a = AW'($urandom);
      exp_q.push_back(a);
      send_event(1'b0, a, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL simul_fill%0d got no handshake want handshake", i); end
    end
    idle(4);
    vectors++; if (count[0] !== 5'd5 || out_req[0] !== 1'b1) begin miscompares++; $display("FAIL simul_pre got count=%0d out_req=%b want 5/1", count[0], out_req[0]); end
    vectors++; if (out_addr[0] !== exp_q[0]) begin miscompares++; $display("FAIL simul_head got %h want %h", out_addr[0], exp_q[0]); end
    a = AW'($urandom);
    in_addr[0] = a;
    exp_q.push_back(a);
    in_req[0]  = 1'b1;
    out_ack[0] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (count[0] !== 5'd5) stable = 1'b0;
    end
    vectors++; if (!stable) begin miscompares++; $display("FAIL simul_count_moved got last %0d want 5 throughout", count[0]); end
    vectors++; if (in_ack[0] !== 1'b1 || out_req[0] !== 1'b0) begin miscompares++; $display("FAIL simul_handshake got in_ack=%b out_req=%b want 1/0", in_ack[0], out_req[0]); end
    in_req[0]  = 1'b0;
    out_ack[0] = 1'b0;
    void'(exp_q.pop_front());
    n = 0;
    while (in_ack[0] !== 1'b0 && n < BOUND) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      recv_event(1'b0, a, ok);
      vectors++; if (!ok || a !== exp_q[0]) begin miscompares++; $display("FAIL simul_data%0d got %h ok=%0d want %h", i, a, ok, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    idle(4);
  endtask

  task automatic test_reset_mid;
    bit ok;
    int n;
    logic [AW-1:0] a;
    out_ack[0] = 1'b0;
    in_addr[0] = 8'h3C;
    in_req[0]  = 1'b1;
    n = 0;
    while (out_req[0] !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
    vectors++; if (in_ack[0] !== 1'b1 || out_req[0] !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre got in_ack=%b out_req=%b want 1/1", in_ack[0], out_req[0]); end
    rst_n = 1'b0;
    #1;
    vectors++; if (in_ack[0] !== 1'b0 || out_req[0] !== 1'b0) begin miscompares++; $display("FAIL rstmid_async got in_ack=%b out_req=%b want 0/0", in_ack[0], out_req[0]); end
    vectors++; if (empty[0] !== 1'b1) begin miscompares++; $display("FAIL rstmid_empty got %b want 1", empty[0]); end
    idle(2);
    rst_n = 1'b1;
    idle(12);
    vectors++; if (in_ack[0] !== 1'b0 || count[0] !== 5'd0) begin miscompares++; $display("FAIL rstmid_held_req got in_ack=%b count=%0d want 0/0", in_ack[0], count[0]); end
    in_req[0] = 1'b0;
    idle(6);
    send_event(1'b0, 8'h7E, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rstmid_new_req got no handshake want handshake"); end
    recv_event(1'b0, a, ok);
    vectors++; if (!ok || a !== 8'h7E) begin miscompares++; $display("FAIL rstmid_new_data got %h ok=%0d want 7e", a, ok); end
    idle(4);
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_drop();
    test_wrap();
    test_simul();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
